// File: rtl/inst_axi_bridge.sv
// Fetch-side responder: turns each aligned fetch request into a single-beat AXI4 read.
// Optional performance counters are compiled in with `define INST_BRIDGE_PERF_EN.
module inst_axi_bridge #(
   parameter int                  AXI_ID_W       = 4,
   parameter logic [AXI_ID_W-1:0] INST_ARID      = '0,
   parameter int                  TIMEOUT_CYCLES = 1023
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pc,
   input  logic                pc_en,
   output logic [31:0]         inst_o,
   output logic                inst_valid,
   output logic                bus_err,
   output logic [31:0]         araddr,
   output logic [AXI_ID_W-1:0] arid,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic                arvalid,
   input  logic                arready,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready
`ifdef INST_BRIDGE_PERF_EN
   ,
   output logic [31:0]         perf_req_cnt,
   output logic [31:0]         perf_wait_cnt
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] ADDR  = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] RESP  = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;

   localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   logic [2:0]      state_q, state_d;
   logic [31:0]     req_pc_q, req_pc_d;
   logic [31:0]     araddr_q, araddr_d;
   logic            arvalid_q, arvalid_d;
   logic [31:0]     data_q, data_d;
   logic            err_q, err_d;
   logic            drain_q, drain_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            pc_hit;
   logic            timeout_hit;

   // kseg0/kseg1 fold onto the low 512 MB; every other segment is identity-mapped.
   function automatic logic [31:0] phys_addr(input logic [31:0] va);
      if (va[31:29] == 3'b100 || va[31:29] == 3'b101) begin
         return {3'b000, va[28:0]};
      end
      return va;
   endfunction

   assign pc_hit      = pc_en && (pc == req_pc_q);
   assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_W'(TO_LAST));

   always_comb begin
      state_d   = state_q;
      req_pc_d  = req_pc_q;
      araddr_d  = araddr_q;
      arvalid_d = arvalid_q;
      data_d    = data_q;
      err_d     = err_q;
      drain_d   = drain_q;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (pc_en && pc[1:0] == 2'b00) begin
               req_pc_d  = pc;
               araddr_d  = phys_addr(pc);
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               cnt_d     = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (rvalid) begin
               data_d  = (rresp == 2'b00) ? rdata : 32'h0;
               err_d   = (rresp != 2'b00);
               drain_d = 1'b0;
               state_d = pc_hit ? RESP : IDLE;
            end else if (timeout_hit) begin
               // The late beat still has to be absorbed before another AR may go out.
               data_d  = 32'h0;
               err_d   = 1'b1;
               drain_d = 1'b1;
               state_d = pc_hit ? RESP : DRAIN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = drain_q ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (rvalid) begin
               drain_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         req_pc_q  <= '0;
         araddr_q  <= '0;
         arvalid_q <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
         drain_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         req_pc_q  <= req_pc_d;
         araddr_q  <= araddr_d;
         arvalid_q <= arvalid_d;
         data_q    <= data_d;
         err_q     <= err_d;
         drain_q   <= drain_d;
         cnt_q     <= cnt_d;
      end
   end

   assign inst_o     = data_q;
   assign inst_valid = (state_q == RESP);
   assign bus_err    = (state_q == RESP) && err_q;
   assign araddr     = araddr_q;
   assign arvalid    = arvalid_q;
   assign rready     = (state_q == DATA) || (state_q == DRAIN);
   assign arid       = INST_ARID;
   assign arlen      = 8'd0;
   assign arsize     = 3'b010;
   assign arburst    = 2'b01;

   logic unused_inputs;
   assign unused_inputs = rlast;

`ifdef INST_BRIDGE_PERF_EN
   logic [31:0] perf_req_q, perf_wait_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_req_q  <= '0;
         perf_wait_q <= '0;
      end else begin
         if (arvalid_q && arready) begin
            perf_req_q <= perf_req_q + 32'd1;
         end
         if (pc_en && !inst_valid) begin
            perf_wait_q <= perf_wait_q + 32'd1;
         end
      end
   end

   assign perf_req_cnt  = perf_req_q;
   assign perf_wait_cnt = perf_wait_q;
`endif

endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: boot, backpressure, redirect, error,
// timeout/drain, misaligned and mid-read reset scenarios with immediate assertions.
module tb_inst_axi_bridge;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic [31:0] inst_o;
   logic        inst_valid;
   logic        bus_err;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   int n_tests = 0;
   int n_fail  = 0;

   inst_axi_bridge #(
      .AXI_ID_W      (4),
      .INST_ARID     (4'h0),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .pc_en     (pc_en),
      .inst_o    (inst_o),
      .inst_valid(inst_valid),
      .bus_err   (bus_err),
      .araddr    (araddr),
      .arid      (arid),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; pc = 32'h0; pc_en = 1'b0; arready = 1'b0;
      rdata = 32'h0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
      step();
      step();
      chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("rst_rready", {31'd0, rready}, 32'd0);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_inst_o", inst_o, 32'h0);
      chk("rst_araddr", araddr, 32'h0);
      chk("const_arlen", {24'd0, arlen}, 32'd0);
      chk("const_arsize", {29'd0, arsize}, 32'd2);
      chk("const_arburst", {30'd0, arburst}, 32'd1);
      chk("const_arid", {28'd0, arid}, 32'd0);
      rst = 1'b1;
      step();

      // Boot: request in cycle 0, AR in cycle 1, rvalid on the 2nd DATA cycle, inst_valid in cycle 4.
      pc = 32'hBFC0_0000; pc_en = 1'b1; arready = 1'b1;
      step();
      chk("boot_arvalid", {31'd0, arvalid}, 32'd1);
      chk("boot_araddr", araddr, 32'h1FC0_0000);
      step();
      chk("boot_data_arvalid", {31'd0, arvalid}, 32'd0);
      chk("boot_rready", {31'd0, rready}, 32'd1);
      step();
      chk("boot_c3_inst_valid", {31'd0, inst_valid}, 32'd0);
      rvalid = 1'b1; rdata = 32'h3C08_BFC0;
      step();
      rvalid = 1'b0;
      chk("boot_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("boot_inst_o", inst_o, 32'h3C08_BFC0);
      chk("boot_bus_err", {31'd0, bus_err}, 32'd0);
      pc_en = 1'b0;
      step();
      chk("boot_pulse_end", {31'd0, inst_valid}, 32'd0);

      // Backpressure: arready low for 5 ADDR cycles, rvalid on the 7th DATA cycle.
      pc = 32'h0040_0004; pc_en = 1'b1; arready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_arvalid_hold", {31'd0, arvalid}, 32'd1);
         chk("bp_araddr_hold", araddr, 32'h0040_0004);
         step();
      end
      chk("bp_arvalid_last", {31'd0, arvalid}, 32'd1);
      arready = 1'b1;
      step();
      arready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("bp_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
         chk("bp_wait_rready", {31'd0, rready}, 32'd1);
         step();
      end
      rvalid = 1'b1; rdata = 32'h8FA2_0010;
      step();
      rvalid = 1'b0;
      chk("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst_o", inst_o, 32'h8FA2_0010);
      pc_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_single_pulse", {31'd0, inst_valid}, 32'd0);
         chk("bp_no_new_ar", {31'd0, arvalid}, 32'd0);
      end

      // Redirect while in DATA: first beat dropped, second AR to the new pc.
      pc = 32'h8000_0100; pc_en = 1'b1; arready = 1'b1;
      step();
      chk("rd_araddr1", araddr, 32'h0000_0100);
      step();
      pc = 32'h8000_0380;
      step();
      rvalid = 1'b1; rdata = 32'h1111_1111;
      step();
      rvalid = 1'b0;
      chk("rd_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rd_idle_arvalid", {31'd0, arvalid}, 32'd0);
      step();
      chk("rd_arvalid2", {31'd0, arvalid}, 32'd1);
      chk("rd_araddr2", araddr, 32'h0000_0380);
      chk("rd_addr_inst_valid", {31'd0, inst_valid}, 32'd0);
      step();
      rvalid = 1'b1; rdata = 32'h2222_2222;
      step();
      rvalid = 1'b0;
      chk("rd_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("rd_inst_o", inst_o, 32'h2222_2222);
      pc_en = 1'b0;
      step();

      // Error response: data forced to 0, bus_err pulses with inst_valid.
      pc = 32'h9FC0_0010; pc_en = 1'b1;
      step();
      chk("err_araddr", araddr, 32'h1FC0_0010);
      step();
      rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
      step();
      rvalid = 1'b0; rresp = 2'b00;
      chk("err_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("err_bus_err", {31'd0, bus_err}, 32'd1);
      chk("err_inst_o", inst_o, 32'h0);
      pc_en = 1'b0;
      step();
      chk("err_bus_err_end", {31'd0, bus_err}, 32'd0);

      // Timeout: no rvalid for 8 DATA cycles, then forced error; late beat drained.
      pc = 32'hBFC0_0020; pc_en = 1'b1;
      step();
      step();
      for (int i = 0; i < 8; i++) begin
         chk("to_wait_inst_valid", {31'd0, inst_valid}, 32'd0);
         chk("to_wait_rready", {31'd0, rready}, 32'd1);
         step();
      end
      chk("to_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("to_bus_err", {31'd0, bus_err}, 32'd1);
      chk("to_inst_o", inst_o, 32'h0);
      pc = 32'hBFC0_0040;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("drain_no_ar", {31'd0, arvalid}, 32'd0);
         chk("drain_rready", {31'd0, rready}, 32'd1);
         chk("drain_inst_valid", {31'd0, inst_valid}, 32'd0);
      end
      rvalid = 1'b1; rdata = 32'h0000_0055;
      step();
      rvalid = 1'b0;
      chk("drain_drop_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("drain_idle_arvalid", {31'd0, arvalid}, 32'd0);
      step();
      chk("post_drain_arvalid", {31'd0, arvalid}, 32'd1);
      chk("post_drain_araddr", araddr, 32'h1FC0_0040);
      step();
      rvalid = 1'b1; rdata = 32'h0000_0066;
      step();
      rvalid = 1'b0;
      chk("post_drain_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("post_drain_inst_o", inst_o, 32'h0000_0066);
      chk("post_drain_bus_err", {31'd0, bus_err}, 32'd0);
      pc_en = 1'b0;
      step();

      // Misaligned pc is ignored.
      pc = 32'h8000_0102; pc_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("misalign_no_ar", {31'd0, arvalid}, 32'd0);
      end
      pc_en = 1'b0;
      step();

      // Reset during DATA: outputs clear immediately, then a clean request.
      pc = 32'h8000_0200; pc_en = 1'b1;
      step();
      step();
      chk("mid_rready", {31'd0, rready}, 32'd1);
      chk("mid_inst_o_before", inst_o, 32'h0000_0066);
      rst = 1'b0;
      #1;
      chk("mid_rst_rready", {31'd0, rready}, 32'd0);
      chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
      chk("mid_rst_araddr", araddr, 32'h0);
      chk("mid_rst_inst_o", inst_o, 32'h0);
      pc_en = 1'b0;
      step();
      rst = 1'b1;
      pc = 32'h8000_0400; pc_en = 1'b1;
      step();
      chk("rel_arvalid", {31'd0, arvalid}, 32'd1);
      chk("rel_araddr", araddr, 32'h0000_0400);
      step();
      rvalid = 1'b1; rdata = 32'h0000_0077;
      step();
      rvalid = 1'b0;
      chk("rel_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("rel_inst_o", inst_o, 32'h0000_0077);
      pc_en = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
